// File: rtl/xconverter_downsize_stream.sv
// Wide-to-narrow write stream converter.
// One DWIDTH_S word (data, byte strobe, address, last) is held and replayed as
// DWIDTH_D beats on a valid/ready master port, starting at the lane selected by
// the word address and optionally skipping lanes whose strobes are all zero.
module xconverter_downsize_stream #(
   parameter int unsigned DWIDTH_S   = 256,
   parameter int unsigned DWIDTH_D   = 32,
   parameter int unsigned DWADDR     = 32,
   parameter int unsigned SKIP_EMPTY = 1
) (
   input  logic                  xclk,
   input  logic                  xreset_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DWIDTH_S-1:0]   s_data,
   input  logic [DWIDTH_S/8-1:0] s_wstrb,
   input  logic [DWADDR-1:0]     s_addr,
   input  logic                  s_last,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DWIDTH_D-1:0]   m_data,
   output logic [DWIDTH_D/8-1:0] m_wstrb,
   output logic [DWADDR-1:0]     m_addr,
   output logic                  m_last,
   output logic                  busy
);

   localparam int unsigned RATIO = DWIDTH_S / DWIDTH_D;
   localparam int unsigned CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int unsigned BO    = $clog2(DWIDTH_D / 8);
   localparam int unsigned DB    = DWIDTH_D / 8;
   localparam int unsigned SB    = DWIDTH_S / 8;
   localparam int unsigned AH    = BO + CW;

   typedef enum logic {
      IDLE  = 1'b0,
      SPLIT = 1'b1
   } state_t;

   state_t               state;
   logic [DWIDTH_S-1:0]  hold_data;
   logic [SB-1:0]        hold_wstrb;
   logic [DWADDR-1:AH]   hold_addr_hi;
   logic                 hold_last;
   logic [RATIO-1:0]     hold_nz;
   logic [CW-1:0]        lane;

   logic [RATIO-1:0]     s_nz;
   logic [CW-1:0]        s_l0;
   logic [CW-1:0]        first_lane;
   logic [CW-1:0]        next_lane;
   logic                 final_lane;
   logic                 unused_addr_bits;

   // Low address bits only select the start lane; the byte offset is dropped.
   assign unused_addr_bits = ^s_addr;

   // Start lane of the incoming word: lowest emitted lane at or above L0.
   always_comb begin
      s_nz       = '0;
      s_l0       = '0;
      first_lane = '0;
      for (int unsigned k = 0; k < RATIO; k++) begin
         s_nz[k] = |s_wstrb[k*DB +: DB];
      end
      if (RATIO > 1) begin
         s_l0 = s_addr[BO +: CW];
      end
      first_lane = s_l0;
      // Descending scan so the lowest qualifying lane is the one that sticks.
      for (int unsigned i = 0; i < RATIO; i++) begin
         if ((SKIP_EMPTY != 0) && ((RATIO - 1 - i) >= 32'(s_l0)) && s_nz[RATIO - 1 - i]) begin
            first_lane = CW'(RATIO - 1 - i);
         end
      end
   end

   // Next emit lane and final-lane detection for the held word.
   always_comb begin
      next_lane  = lane + CW'(1);
      final_lane = (lane == CW'(RATIO - 1));
      if (SKIP_EMPTY != 0) begin
         // Final once no nonzero lane remains above the current one; this also
         // covers the all-empty word, which sits on L0 for its single beat.
         final_lane = 1'b1;
         next_lane  = lane;
         for (int unsigned i = 0; i < RATIO; i++) begin
            if (((RATIO - 1 - i) > 32'(lane)) && hold_nz[RATIO - 1 - i]) begin
               next_lane  = CW'(RATIO - 1 - i);
               final_lane = 1'b0;
            end
         end
      end
   end

   // Accept whenever idle, or on the cycle the final beat of the held word leaves.
   always_comb begin
      s_ready = (state == IDLE) || (m_ready && final_lane);
   end

   // Narrow beat fields are a lane select of the holding register.
   always_comb begin
      m_data  = hold_data[32'(lane)*DWIDTH_D +: DWIDTH_D];
      m_wstrb = hold_wstrb[32'(lane)*DB +: DB];
      m_addr  = '0;
      m_addr[DWADDR-1:AH] = hold_addr_hi;
      m_addr[BO +: CW]    = lane;
      m_last  = m_valid && hold_last && final_lane;
   end

   // Control FSM with holding register, lane pointer and registered flags.
   always_ff @(posedge xclk or negedge xreset_n) begin
      if (!xreset_n) begin
         state        <= IDLE;
         m_valid      <= 1'b0;
         busy         <= 1'b0;
         hold_data    <= '0;
         hold_wstrb   <= '0;
         hold_addr_hi <= '0;
         hold_last    <= 1'b0;
         hold_nz      <= '0;
         lane         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (s_valid) begin
                  hold_data    <= s_data;
                  hold_wstrb   <= s_wstrb;
                  hold_addr_hi <= s_addr[DWADDR-1:AH];
                  hold_last    <= s_last;
                  hold_nz      <= s_nz;
                  lane         <= first_lane;
                  state        <= SPLIT;
                  m_valid      <= 1'b1;
                  busy         <= 1'b1;
               end
            end
            SPLIT: begin
               if (m_ready) begin
                  if (!final_lane) begin
                     lane <= next_lane;
                  end else if (s_valid) begin
                     hold_data    <= s_data;
                     hold_wstrb   <= s_wstrb;
                     hold_addr_hi <= s_addr[DWADDR-1:AH];
                     hold_last    <= s_last;
                     hold_nz      <= s_nz;
                     lane         <= first_lane;
                  end else begin
                     state   <= IDLE;
                     m_valid <= 1'b0;
                     busy    <= 1'b0;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               m_valid <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_xconverter_downsize_stream.sv
// Bench for xconverter_downsize_stream: two 256->32 instances (lane skipping off/on),
// scoreboard queues filled from a lane-list reference model, monitor checks beats.
module tb_xconverter_downsize_stream;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] addr;
      logic        last;
      logic        fin;
   } beat_t;

   logic         xclk;
   logic         xreset_n [2];
   logic         s_valid   [2];
   logic         s_ready   [2];
   logic [255:0] s_data    [2];
   logic [31:0]  s_wstrb   [2];
   logic [31:0]  s_addr    [2];
   logic         s_last    [2];
   logic         m_valid   [2];
   logic         m_ready   [2];
   logic [31:0]  m_data    [2];
   logic [3:0]   m_wstrb   [2];
   logic [31:0]  m_addr    [2];
   logic         m_last    [2];
   logic         busy      [2];

   int checks   = 0;
   int failures = 0;
   bit rnd_mode [2];
   beat_t q0 [$];
   beat_t q1 [$];

   xconverter_downsize_stream #(.DWIDTH_S(256), .DWIDTH_D(32), .DWADDR(32), .SKIP_EMPTY(0)) u0 (
      .xclk(xclk), .xreset_n(xreset_n[0]),
      .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]), .s_wstrb(s_wstrb[0]),
      .s_addr(s_addr[0]), .s_last(s_last[0]),
      .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]), .m_wstrb(m_wstrb[0]),
      .m_addr(m_addr[0]), .m_last(m_last[0]), .busy(busy[0]));

   xconverter_downsize_stream #(.DWIDTH_S(256), .DWIDTH_D(32), .DWADDR(32), .SKIP_EMPTY(1)) u1 (
      .xclk(xclk), .xreset_n(xreset_n[1]),
      .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]), .s_wstrb(s_wstrb[1]),
      .s_addr(s_addr[1]), .s_last(s_last[1]),
      .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]), .m_wstrb(m_wstrb[1]),
      .m_addr(m_addr[1]), .m_last(m_last[1]), .busy(busy[1]));

   initial begin
      xclk = 1'b0;
      forever #5 xclk = ~xclk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic int qsize(input int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction

   // Reference: list the lanes to emit, then turn each into a beat.
   task automatic model_word(input int d, input logic [255:0] data, input logic [31:0] strb,
                             input logic [31:0] addr, input logic last);
      int lanes [$];
      int l0;
      beat_t b;
      l0 = int'(addr[4:2]);
      for (int k = l0; k < 8; k++) begin
         if (d == 0 || strb[k*4 +: 4] != 4'h0) lanes.push_back(k);
      end
      if (lanes.size() == 0) lanes.push_back(l0);
      for (int i = 0; i < lanes.size(); i++) begin
         b.data = data[lanes[i]*32 +: 32];
         b.strb = strb[lanes[i]*4 +: 4];
         b.addr = {addr[31:5], 5'b0} + 32'(lanes[i] * 4);
         b.fin  = (i == lanes.size() - 1);
         b.last = last && b.fin;
         if (d == 0) q0.push_back(b); else q1.push_back(b);
      end
   endtask

   task automatic send(input int d, input logic [255:0] data, input logic [31:0] strb,
                       input logic [31:0] addr, input logic last);
      int n;
      @(negedge xclk);
      s_data[d]  = data;
      s_wstrb[d] = strb;
      s_addr[d]  = addr;
      s_last[d]  = last;
      s_valid[d] = 1'b1;
      #1;
      n = 0;
      while (!s_ready[d] && n < 3000) begin
         @(negedge xclk);
         #1;
         n++;
      end
      if (n >= 3000) begin
         checks++;
         failures++;
         $display("FAIL send_timeout dut=%0d actual=no_accept expected=accept", d);
         s_valid[d] = 1'b0;
      end else begin
         model_word(d, data, strb, addr, last);
      end
   endtask

   task automatic idle(input int d);
      @(negedge xclk);
      s_valid[d] = 1'b0;
   endtask

   task automatic drain(input int d);
      bit done;
      done = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
         @(negedge xclk);
         #3;
         if (qsize(d) == 0 && !m_valid[d]) done = 1'b1;
      end
      chk("drain_done", 64'(done), 64'd1);
   endtask

   function automatic logic [255:0] rnd_data();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [31:0] rnd_strb();
      logic [31:0] v;
      for (int i = 0; i < 8; i++) begin
         case ($urandom_range(0, 2))
            0:       v[i*4 +: 4] = 4'h0;
            1:       v[i*4 +: 4] = 4'hF;
            default: v[i*4 +: 4] = 4'($urandom);
         endcase
      end
      return v;
   endfunction

   // Backpressure source for both instances.
   initial begin
      m_ready[0] = 1'b1;
      m_ready[1] = 1'b1;
      forever begin
         @(negedge xclk);
         for (int d = 0; d < 2; d++) m_ready[d] = rnd_mode[d] ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: pops the scoreboard on every beat handshake, checks stall stability and s_ready.
   initial begin
      bit          stall_prev [2];
      logic [31:0] sv_data [2];
      logic [31:0] sv_addr [2];
      logic [3:0]  sv_strb [2];
      logic        sv_last [2];
      beat_t       b;
      stall_prev[0] = 1'b0;
      stall_prev[1] = 1'b0;
      forever begin
         @(negedge xclk);
         #2;
         for (int d = 0; d < 2; d++) begin
            if (!xreset_n[d]) begin
               stall_prev[d] = 1'b0;
            end else if (m_valid[d]) begin
               if (stall_prev[d]) begin
                  chk("hold_data", 64'(m_data[d]), 64'(sv_data[d]));
                  chk("hold_addr", 64'(m_addr[d]), 64'(sv_addr[d]));
                  chk("hold_strb", 64'(m_wstrb[d]), 64'(sv_strb[d]));
                  chk("hold_last", 64'(m_last[d]), 64'(sv_last[d]));
               end
               if (m_ready[d]) begin
                  stall_prev[d] = 1'b0;
                  if (qsize(d) == 0) begin
                     chk("unexpected_beat", 64'(m_addr[d]), 64'hFFFF_FFFF_FFFF_FFFF);
                  end else begin
                     if (d == 0) b = q0.pop_front(); else b = q1.pop_front();
                     chk("beat_data", 64'(m_data[d]), 64'(b.data));
                     chk("beat_strb", 64'(m_wstrb[d]), 64'(b.strb));
                     chk("beat_addr", 64'(m_addr[d]), 64'(b.addr));
                     chk("beat_last", 64'(m_last[d]), 64'(b.last));
                     chk("s_ready_final", 64'(s_ready[d]), 64'(b.fin));
                  end
               end else begin
                  chk("s_ready_stall", 64'(s_ready[d]), 64'd0);
                  stall_prev[d] = 1'b1;
                  sv_data[d] = m_data[d];
                  sv_addr[d] = m_addr[d];
                  sv_strb[d] = m_wstrb[d];
                  sv_last[d] = m_last[d];
               end
            end else begin
               chk("s_ready_idle", 64'(s_ready[d]), 64'd1);
               stall_prev[d] = 1'b0;
            end
         end
      end
   end

   task automatic chk_reset_outputs(input int d);
      chk("rst_m_valid", 64'(m_valid[d]), 64'd0);
      chk("rst_s_ready", 64'(s_ready[d]), 64'd1);
      chk("rst_m_data",  64'(m_data[d]),  64'd0);
      chk("rst_m_wstrb", 64'(m_wstrb[d]), 64'd0);
      chk("rst_m_addr",  64'(m_addr[d]),  64'd0);
      chk("rst_m_last",  64'(m_last[d]),  64'd0);
      chk("rst_busy",    64'(busy[d]),    64'd0);
   endtask

   initial begin
      int run;
      bit started;
      for (int d = 0; d < 2; d++) begin
         xreset_n[d] = 1'b0;
         s_valid[d]  = 1'b0;
         s_data[d]   = '0;
         s_wstrb[d]  = '0;
         s_addr[d]   = '0;
         s_last[d]   = 1'b0;
         rnd_mode[d] = 1'b0;
      end
      repeat (2) @(negedge xclk);
      #1;
      chk_reset_outputs(0);
      chk_reset_outputs(1);
      @(negedge xclk);
      xreset_n[0] = 1'b1;
      xreset_n[1] = 1'b1;

      // T1 aligned full word, no skipping
      send(0, rnd_data(), 32'hFFFF_FFFF, 32'h100, 1'b1);
      idle(0);
      drain(0);
      // T2 unaligned start lane 5
      send(0, rnd_data(), 32'hFFFF_FFFF, 32'h114, 1'b1);
      idle(0);
      drain(0);
      // T3 skipping: lanes 1 and 6 only, then an all-empty word at lane 2
      send(1, rnd_data(), 32'h0F00_00A0, 32'h100, 1'b1);
      send(1, rnd_data(), 32'h0000_0000, 32'h108, 1'b1);
      send(1, rnd_data(), 32'hF000_0F0F, 32'h10C, 1'b0);
      idle(1);
      drain(1);

      // T4 random words under random backpressure on both instances
      for (int d = 0; d < 2; d++) begin
         rnd_mode[d] = 1'b1;
         for (int w = 0; w < 100; w++) begin
            if ($urandom_range(0, 3) == 0) idle(d);
            send(d, rnd_data(), rnd_strb(), $urandom, 1'($urandom_range(0, 1)));
         end
         idle(d);
         drain(d);
         rnd_mode[d] = 1'b0;
      end

      // T5 back-to-back aligned full words: one unbroken run of valid beats
      run = 0;
      started = 1'b0;
      fork
         begin
            for (int w = 0; w < 16; w++)
               send(0, rnd_data(), 32'hFFFF_FFFF, {$urandom_range(0, 65535), 5'b0}, 1'b1);
            idle(0);
         end
         begin
            for (int c = 0; c < 600; c++) begin
               @(negedge xclk);
               #3;
               if (m_valid[0]) begin
                  started = 1'b1;
                  run++;
               end else if (started) begin
                  break;
               end
            end
         end
      join
      chk("t5_run_length", 64'(run), 64'd128);
      drain(0);

      // T6 reset on beat 3 of 8, then a fresh unaligned word
      send(0, rnd_data(), 32'hFFFF_FFFF, 32'h200, 1'b1);
      @(posedge xclk);
      @(posedge xclk);
      @(posedge xclk);
      #1;
      chk("t6_beat3_addr", 64'(m_addr[0]), 64'h208);
      xreset_n[0] = 1'b0;
      s_valid[0]  = 1'b0;
      #1;
      chk_reset_outputs(0);
      q0.delete();
      @(negedge xclk);
      xreset_n[0] = 1'b1;
      send(0, rnd_data(), 32'hFFFF_FFFF, 32'h30C, 1'b1);
      idle(0);
      drain(0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
